// File: rtl/pulse_trig_pkg.sv
// Shared definitions for the pulse trigger processor: trigger-word and
// readout-record field positions, FSM state bit indices, and trig_length codes.
package pulse_trig_pkg;

    // Incoming Pulse Trigger FIFO word fields
    localparam int TRIG_TS_LSB  = 0;
    localparam int TRIG_TS_W    = 44;
    localparam int TRIG_NUM_LSB = 44;
    localparam int TRIG_NUM_W   = 24;
    localparam int TRIG_LEN_LSB = 68;
    localparam int TRIG_LEN_W   = 2;

    // Outgoing readout record fields
    localparam int REC_TS_LSB      = 0;
    localparam int REC_NUM_LSB     = 44;
    localparam int REC_LEN_LSB     = 68;
    localparam int REC_MASK_LSB    = 70;
    localparam int REC_TIMEOUT_BIT = 75;

    // One-hot FSM encoding; bit 3 is reserved and always 0
    localparam int ST_IDLE     = 0;
    localparam int ST_WAIT_ACQ = 1;
    localparam int ST_SEND     = 2;
    localparam int STATE_W     = 4;

    localparam logic [STATE_W-1:0] STATE_IDLE     = 4'b0001;
    localparam logic [STATE_W-1:0] STATE_WAIT_ACQ = 4'b0010;
    localparam logic [STATE_W-1:0] STATE_SEND     = 4'b0100;

    typedef enum logic [1:0] {
        TRIG_NONE     = 2'b00,
        TRIG_AM       = 2'b01,
        TRIG_LASER    = 2'b10,
        TRIG_LASER_AM = 2'b11
    } trig_len_e;

endpackage

// File: rtl/pulse_trigger_processor_chan_done_tracker.sv
// chan_done_tracker: per-channel count of acquisitions completed but not yet
// claimed by a readout record. Saturates at all-ones and flags the lost pulse.
module chan_done_tracker #(
    parameter int PEND_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic consume,
    output logic nonzero,
    output logic sat_hit
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend_q;
    logic              do_consume;

    // A consume request against an empty counter is ignored
    assign do_consume = consume & (pend_q != '0);
    assign nonzero    = (pend_q != '0);
    assign sat_hit    = inc & ~do_consume & (pend_q == PEND_MAX);

    // Pending count update: simultaneous inc and consume cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else if (inc && !do_consume) begin
            if (pend_q != PEND_MAX) begin
                pend_q <= pend_q + 1'b1;
            end
        end else if (!inc && do_consume) begin
            pend_q <= pend_q - 1'b1;
        end
    end

endmodule

// File: rtl/pulse_trigger_processor.sv
// pulse_trigger_processor: pops one trigger word, waits for all enabled
// channels to finish (or a timeout), then hands one record downstream.
// Optional per-trigger-type counters are built when
// PULSE_TRIG_TYPE_COUNTERS_EN is defined.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | fifo_ready high; pop and latch the next trigger word
//   WAIT_ACQ | wait for every enabled channel to have a pending done
//   SEND     | hold the record on info_data until info_ready
module pulse_trigger_processor
    import pulse_trig_pkg::*;
#(
    parameter int NCHAN  = 5,
    parameter int PEND_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fifo_valid,
    input  logic [127:0]       fifo_data,
    output logic               fifo_ready,
    input  logic [NCHAN-1:0]   chan_en,
    input  logic [NCHAN-1:0]   acq_done,
    input  logic [15:0]        thres_acq_timeout,
    input  logic               counters_clear,
    output logic               info_valid,
    output logic [127:0]       info_data,
    input  logic               info_ready,
    output logic [STATE_W-1:0] state,
    output logic [31:0]        processed_count,
    output logic [31:0]        timeout_count,
    output logic               pending_overflow
`ifdef PULSE_TRIG_TYPE_COUNTERS_EN
    ,
    output logic [31:0]        laser_count,
    output logic [31:0]        am_count,
    output logic [31:0]        laser_am_count
`endif
);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [15:0]           timer_q;
    logic [TRIG_LEN_W-1:0] len_q;
    logic [TRIG_NUM_W-1:0] num_q;
    logic [TRIG_TS_W-1:0]  ts_q;
    logic [NCHAN-1:0]      pend_nz;
    logic [NCHAN-1:0]      sat_hit;
    logic [NCHAN-1:0]      all_ok;
    logic [NCHAN-1:0]      done_mask;
    logic                  close_rec;
    logic                  close_timeout;
    logic                  timeout_hit;
    logic                  send_hs;
    logic [127:0]          rec_d;

    wire unused_fifo_bits = ^fifo_data[127:TRIG_LEN_LSB+TRIG_LEN_W];

    genvar c;
    generate
        for (c = 0; c < NCHAN; c++) begin : g_chan
            chan_done_tracker #(.PEND_W(PEND_W)) u_trk (
                .clk     (clk),
                .reset   (reset),
                .inc     (acq_done[c]),
                .consume (done_mask[c]),
                .nonzero (pend_nz[c]),
                .sat_hit (sat_hit[c])
            );
        end
    endgenerate

    assign all_ok      = ~chan_en | pend_nz;
    assign timeout_hit = (thres_acq_timeout != 16'd0) &&
                         (timer_q == thres_acq_timeout - 16'd1);
    assign state       = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the close decision that drives channel consumption
    always_comb begin
        state_d       = state_q;
        done_mask     = '0;
        close_rec     = 1'b0;
        close_timeout = 1'b0;
        if (state_q[ST_IDLE]) begin
            if (fifo_valid) begin
                state_d = STATE_WAIT_ACQ;
            end
        end else if (state_q[ST_WAIT_ACQ]) begin
            if (&all_ok) begin
                done_mask = chan_en;
                close_rec = 1'b1;
                state_d   = STATE_SEND;
            end else if (timeout_hit) begin
                done_mask     = chan_en & pend_nz;
                close_rec     = 1'b1;
                close_timeout = 1'b1;
                state_d       = STATE_SEND;
            end
        end else if (state_q[ST_SEND]) begin
            if (info_ready) begin
                state_d = STATE_IDLE;
            end
        end else begin
            state_d = STATE_IDLE;
        end
    end

    // Outputs decoded from the state register
    always_comb begin
        fifo_ready = state_q[ST_IDLE];
        info_valid = state_q[ST_SEND];
        send_hs    = state_q[ST_SEND] & info_ready;
    end

    // Record assembly from the latched trigger word and close decision
    always_comb begin
        rec_d = '0;
        rec_d[REC_TS_LSB  +: TRIG_TS_W]  = ts_q;
        rec_d[REC_NUM_LSB +: TRIG_NUM_W] = num_q;
        rec_d[REC_LEN_LSB +: TRIG_LEN_W] = len_q;
        rec_d[REC_MASK_LSB +: NCHAN]     = done_mask;
        rec_d[REC_TIMEOUT_BIT]           = close_timeout;
    end

    // Trigger latch, wait timer and record register
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q   <= '0;
            len_q     <= '0;
            num_q     <= '0;
            ts_q      <= '0;
            info_data <= '0;
        end else begin
            if (state_q[ST_IDLE] && fifo_valid) begin
                len_q   <= fifo_data[TRIG_LEN_LSB +: TRIG_LEN_W];
                num_q   <= fifo_data[TRIG_NUM_LSB +: TRIG_NUM_W];
                ts_q    <= fifo_data[TRIG_TS_LSB  +: TRIG_TS_W];
                timer_q <= '0;
            end else if (state_q[ST_WAIT_ACQ] && !close_rec && timer_q != 16'hFFFF) begin
                timer_q <= timer_q + 16'd1;
            end
            if (close_rec) begin
                info_data <= rec_d;
            end else if (send_hs) begin
                info_data <= '0;
            end
        end
    end

    // Status counters; a clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || counters_clear) begin
            processed_count  <= '0;
            timeout_count    <= '0;
            pending_overflow <= 1'b0;
`ifdef PULSE_TRIG_TYPE_COUNTERS_EN
            laser_count      <= '0;
            am_count         <= '0;
            laser_am_count   <= '0;
`endif
        end else begin
            if (send_hs) begin
                processed_count <= processed_count + 32'd1;
            end
            if (close_timeout) begin
                timeout_count <= timeout_count + 32'd1;
            end
            if (|sat_hit) begin
                pending_overflow <= 1'b1;
            end
`ifdef PULSE_TRIG_TYPE_COUNTERS_EN
            if (send_hs) begin
                case (trig_len_e'(len_q))
                    TRIG_LASER:    laser_count    <= laser_count + 32'd1;
                    TRIG_AM:       am_count       <= am_count + 32'd1;
                    TRIG_LASER_AM: laser_am_count <= laser_am_count + 32'd1;
                    default:       ;
                endcase
            end
`endif
        end
    end

endmodule

// File: tb/tb_pulse_trigger_processor.sv
// Directed bench for pulse_trigger_processor; expected records are built
// from hand-chosen trigger fields. Type counters are checked when
// PULSE_TRIG_TYPE_COUNTERS_EN is defined.
module tb_pulse_trigger_processor;

    logic         clk = 1'b0;
    logic         reset;
    logic         fifo_valid;
    logic [127:0] fifo_data;
    logic         fifo_ready;
    logic [4:0]   chan_en;
    logic [4:0]   acq_done;
    logic [15:0]  thres_acq_timeout;
    logic         counters_clear;
    logic         info_valid;
    logic [127:0] info_data;
    logic         info_ready;
    logic [3:0]   state;
    logic [31:0]  processed_count;
    logic [31:0]  timeout_count;
    logic         pending_overflow;
`ifdef PULSE_TRIG_TYPE_COUNTERS_EN
    logic [31:0]  laser_count;
    logic [31:0]  am_count;
    logic [31:0]  laser_am_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    pulse_trigger_processor #(.NCHAN(5), .PEND_W(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_valid        (fifo_valid),
        .fifo_data         (fifo_data),
        .fifo_ready        (fifo_ready),
        .chan_en           (chan_en),
        .acq_done          (acq_done),
        .thres_acq_timeout (thres_acq_timeout),
        .counters_clear    (counters_clear),
        .info_valid        (info_valid),
        .info_data         (info_data),
        .info_ready        (info_ready),
        .state             (state),
        .processed_count   (processed_count),
        .timeout_count     (timeout_count),
        .pending_overflow  (pending_overflow)
`ifdef PULSE_TRIG_TYPE_COUNTERS_EN
        ,
        .laser_count       (laser_count),
        .am_count          (am_count),
        .laser_am_count    (laser_am_count)
`endif
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_rec(input logic [1:0] len, input logic [23:0] num,
                                            input logic [43:0] ts, input logic [4:0] mask,
                                            input logic to);
        logic [127:0] r;
        r         = '0;
        r[43:0]   = ts;
        r[67:44]  = num;
        r[69:68]  = len;
        r[74:70]  = mask;
        r[75]     = to;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one word while in IDLE; returns at the first WAIT_ACQ negedge
    task automatic push(input logic [1:0] len, input logic [23:0] num, input logic [43:0] ts);
        fifo_data  = {58'd0, len, num, ts};
        fifo_valid = 1'b1;
        tick();
        fifo_valid = 1'b0;
    endtask

    task automatic handshake();
        info_ready = 1'b1;
        tick();
        info_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] held;
        reset = 1'b1; fifo_valid = 1'b0; fifo_data = '0; chan_en = '0; acq_done = '0;
        thres_acq_timeout = '0; counters_clear = 1'b0; info_ready = 1'b0;
        tick(); tick();
        check_val("rst_state", state, 4'b0001);
        check_val("rst_valid", info_valid, 1'b0);
        check_val("rst_data", info_data, '0);
        check_val("rst_proc", processed_count, 32'd0);
        check_val("rst_tmo", timeout_count, 32'd0);
        check_val("rst_ovf", pending_overflow, 1'b0);
        check_val("rst_fifo_ready", fifo_ready, 1'b1);
        reset = 1'b0;
        tick();

        // basic record: ch0 then ch1 complete after the pop
        chan_en = 5'b00011;
        push(2'b10, 24'd1, 44'h100);
        check_val("t1_wait", state, 4'b0010);
        tick(); tick();
        acq_done = 5'b00001; tick(); acq_done = '0;
        tick(); tick();
        check_val("t1_no_early", info_valid, 1'b0);
        acq_done = 5'b00010; tick(); acq_done = '0;
        check_val("t1_lat", info_valid, 1'b0);
        tick();
        check_val("t1_valid", info_valid, 1'b1);
        check_val("t1_rec", info_data, mk_rec(2'b10, 24'd1, 44'h100, 5'b00011, 1'b0));
        check_val("t1_no_pop", fifo_ready, 1'b0);
        handshake();
        check_val("t1_idle", state, 4'b0001);
        check_val("t1_valid_lo", info_valid, 1'b0);
        check_val("t1_data_zero", info_data, '0);
        check_val("t1_proc", processed_count, 32'd1);
        check_val("t1_tmo", timeout_count, 32'd0);

        // completions arrive before the trigger word
        acq_done = 5'b00011; tick(); acq_done = '0;
        repeat (9) tick();
        push(2'b01, 24'd2, 44'h200);
        check_val("t2_wait", state, 4'b0010);
        tick();
        check_val("t2_valid", info_valid, 1'b1);
        check_val("t2_rec", info_data, mk_rec(2'b01, 24'd2, 44'h200, 5'b00011, 1'b0));
        handshake();
        check_val("t2_proc", processed_count, 32'd2);

        // pend drained: next trigger times out with an empty mask
        thres_acq_timeout = 16'd4;
        push(2'b00, 24'd3, 44'h300);
        repeat (3) tick();
        check_val("t2b_not_yet", info_valid, 1'b0);
        tick();
        check_val("t2b_valid", info_valid, 1'b1);
        check_val("t2b_rec", info_data, mk_rec(2'b00, 24'd3, 44'h300, 5'b00000, 1'b1));
        check_val("t2b_tmo", timeout_count, 32'd1);
        handshake();
        check_val("t2b_proc", processed_count, 32'd3);

        counters_clear = 1'b1; tick(); counters_clear = 1'b0;
        check_val("clr_proc", processed_count, 32'd0);
        check_val("clr_tmo", timeout_count, 32'd0);

        // timeout with partial completion
        chan_en = 5'b00111;
        thres_acq_timeout = 16'd20;
        push(2'b10, 24'd4, 44'h400);
        acq_done = 5'b00001; tick(); acq_done = '0;
        repeat (18) tick();
        check_val("t3_not_yet", info_valid, 1'b0);
        tick();
        check_val("t3_valid", info_valid, 1'b1);
        check_val("t3_rec", info_data, mk_rec(2'b10, 24'd4, 44'h400, 5'b00001, 1'b1));
        check_val("t3_tmo", timeout_count, 32'd1);
        handshake();
        check_val("t3_proc", processed_count, 32'd1);

        // backpressure in SEND with a word waiting in the FIFO
        chan_en = '0;
        thres_acq_timeout = '0;
        push(2'b01, 24'd5, 44'h500);
        tick();
        held = mk_rec(2'b01, 24'd5, 44'h500, 5'b00000, 1'b0);
        check_val("t4_rec", info_data, held);
        fifo_data  = {58'd0, 2'b11, 24'd6, 44'h600};
        fifo_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_val("t4_stable", info_data, held);
            check_val("t4_no_pop", fifo_ready, 1'b0);
        end
        handshake();
        check_val("t4_idle", state, 4'b0001);
        check_val("t4_valid_lo", info_valid, 1'b0);
        check_val("t4_data_zero", info_data, '0);
        check_val("t4_proc", processed_count, 32'd2);
        tick();
        fifo_valid = 1'b0;
        check_val("t4_second_pop", state, 4'b0010);
        tick();
        check_val("t4_rec2", info_data, mk_rec(2'b11, 24'd6, 44'h600, 5'b00000, 1'b0));
        info_ready = 1'b1; counters_clear = 1'b1;
        tick();
        info_ready = 1'b0; counters_clear = 1'b0;
        check_val("clr_wins", processed_count, 32'd0);

        // pending counter saturation and sticky overflow
        acq_done = 5'b00100;
        repeat (15) tick();
        check_val("t5_no_ovf", pending_overflow, 1'b0);
        tick();
        acq_done = '0;
        check_val("t5_ovf", pending_overflow, 1'b1);
        counters_clear = 1'b1; tick(); counters_clear = 1'b0;
        check_val("t5_ovf_clr", pending_overflow, 1'b0);
        // exactly 15 pending on ch2: 15 immediate records, then a timeout
        chan_en = 5'b00100;
        for (int i = 0; i < 15; i++) begin
            push(2'b00, 24'(i + 16), 44'(i));
            tick();
            check_val("t5_drain", info_data, mk_rec(2'b00, 24'(i + 16), 44'(i), 5'b00100, 1'b0));
            handshake();
        end
        thres_acq_timeout = 16'd3;
        push(2'b00, 24'd99, 44'h999);
        repeat (3) tick();
        check_val("t5_empty", info_data, mk_rec(2'b00, 24'd99, 44'h999, 5'b00000, 1'b1));
        handshake();
        check_val("t5_proc", processed_count, 32'd16);
        check_val("t5_ovf_kept", pending_overflow, 1'b0);

        // reset while waiting
        chan_en = 5'b00011;
        thres_acq_timeout = '0;
        push(2'b10, 24'd7, 44'h700);
        check_val("t6_wait", state, 4'b0010);
        reset = 1'b1; tick(); reset = 1'b0;
        check_val("t6_state", state, 4'b0001);
        check_val("t6_valid", info_valid, 1'b0);
        check_val("t6_proc", processed_count, 32'd0);
        check_val("t6_tmo", timeout_count, 32'd0);

`ifdef PULSE_TRIG_TYPE_COUNTERS_EN
        chan_en = '0;
        for (int i = 0; i < 3; i++) begin
            push(2'b11, 24'(i), 44'h0);
            tick();
            handshake();
        end
        push(2'b00, 24'd50, 44'h0);
        tick();
        handshake();
        push(2'b10, 24'd51, 44'h0);
        tick();
        handshake();
        check_val("tc_laser_am", laser_am_count, 32'd3);
        check_val("tc_laser", laser_count, 32'd1);
        check_val("tc_am", am_count, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
